mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch channel and the load/store channel of the multi-cycle RISC-V core. Each upstream channel keeps the core's valid/ack request and response handshakes. The block grants one transaction at a time with round-robin fairness, steers the response back to its owner, and keeps grant and contention counters for the performance-counter bank.

## Interface
- No parameters; address and data are 32 bits, the write strobe is 4 bits.
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Inst_Req_Valid  in  1  fetch request.
- Inst_Addr  in  32  fetch address (core PC).
- Inst_Req_Ack  out  1  fetch request accepted.
- Instruction  out  32  fetched word.
- Inst_Valid  out  1  fetched word valid.
- Inst_Ack  in  1  core accepts the fetched word.
- Address  in  32  data address, word aligned.
- MemWrite  in  1  store request.
- MemRead  in  1  load request.
- Write_data  in  32  store data.
- Write_strb  in  4  store byte enables.
- Mem_Req_Ack  out  1  data request accepted.
- Read_data  out  32  load data.
- Read_data_Valid  out  1  load data valid.
- Read_data_Ack  in  1  core accepts the load data.
- Bus_Req_Valid  out  1  downstream request.
- Bus_Req_Ack  in  1  downstream accepts the request.
- Bus_Addr  out  32  downstream address.
- Bus_Wen  out  1  1 = write, 0 = read.
- Bus_Wdata  out  32  downstream write data.
- Bus_Wstrb  out  4  downstream byte enables.
- Bus_Rdata  in  32  downstream read data.
- Bus_Rdata_Valid  in  1  downstream read data valid.
- Bus_Rdata_Ack  out  1  read data accepted.
- Grant_Inst_Cnt  out  32  count of granted fetches.
- Grant_Data_Cnt  out  32  count of granted loads and stores.
- Conflict_Cnt  out  32  count of IDLE cycles with both channels requesting.

## Operation
- States are one-hot: IDLE, I_REQ, I_RESP, D_REQ, D_RESP. A `last` register records the last grant (0 = inst, 1 = data).
- A channel requests when inst_req = Inst_Req_Valid or data_req = MemRead | MemWrite.
- IDLE, single requester: go to I_REQ or D_REQ.
- IDLE, both requesting: grant the channel not equal to `last`, increment Conflict_Cnt.
- On every grant: update `last` and increment the matching grant counter.
- I_REQ:
  - Bus_Req_Valid = 1, Bus_Addr = Inst_Addr, Bus_Wen = 0, Bus_Wstrb = 0, Bus_Wdata = 0.
  - Inst_Req_Ack = Bus_Req_Ack (combinational).
  - On Bus_Req_Ack go to I_RESP.
- D_REQ:
  - Bus_Req_Valid = 1, Bus_Addr = Address, Bus_Wen = MemWrite, Bus_Wdata = Write_data.
  - Bus_Wstrb = MemWrite ? Write_strb : 0.
  - Mem_Req_Ack = Bus_Req_Ack.
  - On ack: if MemWrite, go to IDLE (a store has no response phase); otherwise go to D_RESP.
  - MemRead and MemWrite both high: treated as a store.
- I_RESP:
  - Instruction = Bus_Rdata, Inst_Valid = Bus_Rdata_Valid, Bus_Rdata_Ack = Inst_Ack.
  - When Bus_Rdata_Valid & Inst_Ack, go to IDLE.
- D_RESP: same as I_RESP with Read_data, Read_data_Valid and Read_data_Ack.
- Outside these states, all upstream acks and valids are 0 and Bus_Rdata_Ack = 0. Inst_Ack or Read_data_Ack arriving in any other state is ignored.
- Exactly one transaction is outstanding at a time. A request from the non-granted channel waits in IDLE and is not lost.
- Counters are 32-bit, wrap from 0xFFFFFFFF to 0, and never saturate.

## Timing
- Reset (asynchronous, applied at any time including mid-transaction):
  - state = IDLE, `last` = 1 (so inst wins the first conflict), all counters = 0.
  - Every valid/ack output is 0; data outputs are 0.
  - A transaction in flight is abandoned. The downstream memory shares the same reset.
- Grant decision is registered: a request seen in IDLE at cycle N drives Bus_Req_Valid at N+1.
- Upstream request ack is combinational from Bus_Req_Ack: same cycle, no extra latency.
- Minimum read: request at N, bus ack at N+1, data valid at N+2 accepted the same cycle, back in IDLE at N+3.
- Minimum store: request at N, bus ack at N+1, IDLE at N+2.
- Payload must be held stable by the requester until its ack; the block does not latch it.
- The response path is combinational pass-through: zero added latency.

## Test plan
- Lone fetch: Inst_Req_Valid, Inst_Addr=0x100; bus acks immediately and returns 0x00000013 one cycle later.
  - Required: Bus_Addr=0x100 with Bus_Wen=0; Instruction=0x00000013 with Inst_Valid=1; Grant_Inst_Cnt=1; state IDLE after Inst_Ack.
- Conflict sequence: both channels hold requests for 3 transactions after reset.
  - Required grants: inst, data, inst; Conflict_Cnt=3 (fetch re-requested each time).
- Store: MemWrite, Address=0x200, Write_data=0xDEADBEEF, Write_strb=4'b0011.
  - Required: Bus_Wen=1, Bus_Wstrb=0011, Mem_Req_Ack pulses with Bus_Req_Ack, no response phase, IDLE next cycle.
- Backpressure:
  - Bus_Req_Ack held low 5 cycles: required Bus_Req_Valid stays high and Mem_Req_Ack stays 0 throughout.
  - Read_data_Ack held low 3 cycles with data valid: required Bus_Rdata_Ack=0 and state stays D_RESP.
- Reset mid-read: assert rst in D_RESP between clock edges.
  - Required: outputs drop immediately, counters=0, next inst/data conflict grants inst.
- Wrap: force Grant_Data_Cnt=0xFFFFFFFF, issue one load -> required Grant_Data_Cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Core-side fetch/load-store handshakes, downstream memory bus and perf counters
// of the shared memory port; master = arbiter view, slave = core/memory view.
interface mem_port_arbiter_if;
  logic        Inst_Req_Valid;
  logic [31:0] Inst_Addr;
  logic        Inst_Req_Ack;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ack;
  logic [31:0] Address;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ack;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ack;
  logic        Bus_Req_Valid;
  logic        Bus_Req_Ack;
  logic [31:0] Bus_Addr;
  logic        Bus_Wen;
  logic [31:0] Bus_Wdata;
  logic [3:0]  Bus_Wstrb;
  logic [31:0] Bus_Rdata;
  logic        Bus_Rdata_Valid;
  logic        Bus_Rdata_Ack;
  logic [31:0] Grant_Inst_Cnt;
  logic [31:0] Grant_Data_Cnt;
  logic [31:0] Conflict_Cnt;

  modport master (
    input  Inst_Req_Valid, Inst_Addr, Inst_Ack,
    input  Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ack,
    input  Bus_Req_Ack, Bus_Rdata, Bus_Rdata_Valid,
    output Inst_Req_Ack, Instruction, Inst_Valid,
    output Mem_Req_Ack, Read_data, Read_data_Valid,
    output Bus_Req_Valid, Bus_Addr, Bus_Wen, Bus_Wdata, Bus_Wstrb, Bus_Rdata_Ack,
    output Grant_Inst_Cnt, Grant_Data_Cnt, Conflict_Cnt
  );

  modport slave (
    output Inst_Req_Valid, Inst_Addr, Inst_Ack,
    output Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ack,
    output Bus_Req_Ack, Bus_Rdata, Bus_Rdata_Valid,
    input  Inst_Req_Ack, Instruction, Inst_Valid,
    input  Mem_Req_Ack, Read_data, Read_data_Valid,
    input  Bus_Req_Valid, Bus_Addr, Bus_Wen, Bus_Wdata, Bus_Wstrb, Bus_Rdata_Ack,
    input  Grant_Inst_Cnt, Grant_Data_Cnt, Conflict_Cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of fetch and load/store channels onto one memory port.
// Grant is registered (one cycle); request acks and response path are combinational pass-through.
module mem_port_arbiter (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master port
);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    I_REQ  = 5'b00010,
    I_RESP = 5'b00100,
    D_REQ  = 5'b01000,
    D_RESP = 5'b10000
  } state_t;

  state_t      state, state_nxt;
  logic        last;
  logic [31:0] grant_inst_cnt, grant_data_cnt, conflict_cnt;
  logic        inst_req, data_req, in_idle;
  logic        grant_inst, grant_data, conflict;

  assign inst_req = port.Inst_Req_Valid;
  assign data_req = port.MemRead | port.MemWrite;
  assign in_idle  = (state == IDLE);

  // On contention the channel that did not win last time is granted.
  assign grant_inst = in_idle & inst_req & (~data_req | last);
  assign grant_data = in_idle & data_req & (~inst_req | ~last);
  assign conflict   = in_idle & inst_req & data_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (grant_inst) state_nxt = I_REQ;
              else if (grant_data) state_nxt = D_REQ;
      I_REQ:  if (port.Bus_Req_Ack) state_nxt = I_RESP;
      I_RESP: if (port.Bus_Rdata_Valid & port.Inst_Ack) state_nxt = IDLE;
      // A store (including read+write together) has no response phase.
      D_REQ:  if (port.Bus_Req_Ack) state_nxt = port.MemWrite ? IDLE : D_RESP;
      D_RESP: if (port.Bus_Rdata_Valid & port.Read_data_Ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    port.Bus_Req_Valid   = 1'b0;
    port.Bus_Addr        = 32'h0;
    port.Bus_Wen         = 1'b0;
    port.Bus_Wdata       = 32'h0;
    port.Bus_Wstrb       = 4'h0;
    port.Bus_Rdata_Ack   = 1'b0;
    port.Inst_Req_Ack    = 1'b0;
    port.Instruction     = 32'h0;
    port.Inst_Valid      = 1'b0;
    port.Mem_Req_Ack     = 1'b0;
    port.Read_data       = 32'h0;
    port.Read_data_Valid = 1'b0;
    case (state)
      I_REQ: begin
        port.Bus_Req_Valid = 1'b1;
        port.Bus_Addr      = port.Inst_Addr;
        port.Inst_Req_Ack  = port.Bus_Req_Ack;
      end
      I_RESP: begin
        port.Instruction   = port.Bus_Rdata;
        port.Inst_Valid    = port.Bus_Rdata_Valid;
        port.Bus_Rdata_Ack = port.Inst_Ack;
      end
      D_REQ: begin
        port.Bus_Req_Valid = 1'b1;
        port.Bus_Addr      = port.Address;
        port.Bus_Wen       = port.MemWrite;
        port.Bus_Wdata     = port.Write_data;
        port.Bus_Wstrb     = port.MemWrite ? port.Write_strb : 4'h0;
        port.Mem_Req_Ack   = port.Bus_Req_Ack;
      end
      D_RESP: begin
        port.Read_data       = port.Bus_Rdata;
        port.Read_data_Valid = port.Bus_Rdata_Valid;
        port.Bus_Rdata_Ack   = port.Read_data_Ack;
      end
      default: ;
    endcase
  end

  // last resets to data so the first conflict after reset goes to fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last           <= 1'b1;
      grant_inst_cnt <= 32'h0;
      grant_data_cnt <= 32'h0;
      conflict_cnt   <= 32'h0;
    end else begin
      if (grant_inst) begin
        last           <= 1'b0;
        grant_inst_cnt <= grant_inst_cnt + 32'h1;
      end else if (grant_data) begin
        last           <= 1'b1;
        grant_data_cnt <= grant_data_cnt + 32'h1;
      end
      if (conflict) conflict_cnt <= conflict_cnt + 32'h1;
    end
  end

  assign port.Grant_Inst_Cnt = grant_inst_cnt;
  assign port.Grant_Data_Cnt = grant_data_cnt;
  assign port.Conflict_Cnt   = conflict_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter dut (.clk(clk), .rst(rst), .port(bus));

  int checks = 0;
  int failures = 0;

  // Response snapshots taken by the bus/core driver.
  logic        snap_iack, snap_dack, snap_wen;
  logic        snap_ivld, snap_rvld, snap_rack;
  logic [31:0] snap_instr, snap_rdata;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs;
    bus.Inst_Req_Valid = 0; bus.Inst_Addr = 0; bus.Inst_Ack = 0;
    bus.Address = 0; bus.MemWrite = 0; bus.MemRead = 0;
    bus.Write_data = 0; bus.Write_strb = 0; bus.Read_data_Ack = 0;
    bus.Bus_Req_Ack = 0; bus.Bus_Rdata = 0; bus.Bus_Rdata_Valid = 0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Plays downstream memory and the owning core channel for one granted transaction.
  // Entered at the negedge of the first request cycle; returns at a negedge in IDLE.
  task automatic serve(input int ack_dly, input int vld_dly, input int cack_dly, input logic [31:0] rd);
    snap_ivld = 0; snap_rvld = 0; snap_rack = 0; snap_instr = 0; snap_rdata = 0;
    bus.Bus_Req_Ack = 0;
    repeat (ack_dly) @(negedge clk);
    bus.Bus_Req_Ack = 1;
    #1;
    snap_iack = bus.Inst_Req_Ack;
    snap_dack = bus.Mem_Req_Ack;
    snap_wen  = bus.Bus_Wen;
    @(negedge clk);
    bus.Bus_Req_Ack = 0;
    if (snap_iack) bus.Inst_Req_Valid = 0;
    if (snap_dack) begin bus.MemRead = 0; bus.MemWrite = 0; end
    if (!snap_wen && (snap_iack || snap_dack)) begin
      repeat (vld_dly) @(negedge clk);
      bus.Bus_Rdata = rd;
      bus.Bus_Rdata_Valid = 1;
      repeat (cack_dly) @(negedge clk);
      if (snap_iack) bus.Inst_Ack = 1; else bus.Read_data_Ack = 1;
      #1;
      snap_ivld = bus.Inst_Valid;      snap_instr = bus.Instruction;
      snap_rvld = bus.Read_data_Valid; snap_rdata = bus.Read_data;
      snap_rack = bus.Bus_Rdata_Ack;
      @(negedge clk);
      bus.Bus_Rdata_Valid = 0; bus.Bus_Rdata = 0;
      bus.Inst_Ack = 0; bus.Read_data_Ack = 0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    bus.Bus_Req_Ack = 1; bus.Bus_Rdata_Valid = 1; bus.Inst_Ack = 1; bus.Read_data_Ack = 1;
    bus.Bus_Rdata = 32'h5555_AAAA;
    #3;
    checks++;
    if ({bus.Bus_Req_Valid, bus.Inst_Req_Ack, bus.Mem_Req_Ack, bus.Inst_Valid,
         bus.Read_data_Valid, bus.Bus_Rdata_Ack} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 000000", {bus.Bus_Req_Valid, bus.Inst_Req_Ack,
               bus.Mem_Req_Ack, bus.Inst_Valid, bus.Read_data_Valid, bus.Bus_Rdata_Ack});
    end
    checks++;
    if ({bus.Bus_Addr, bus.Instruction, bus.Read_data, bus.Bus_Wdata} !== 128'h0) begin
      failures++;
      $display("FAIL reset_data: addr %h instr %h rdata %h wdata %h expected all 0",
               bus.Bus_Addr, bus.Instruction, bus.Read_data, bus.Bus_Wdata);
    end
    do_reset();
    checks++;
    if ({bus.Grant_Inst_Cnt, bus.Grant_Data_Cnt, bus.Conflict_Cnt} !== 96'h0) begin
      failures++;
      $display("FAIL reset_cnt: got %h %h %h expected 0 0 0",
               bus.Grant_Inst_Cnt, bus.Grant_Data_Cnt, bus.Conflict_Cnt);
    end
  endtask

  task automatic test_lone_fetch;
    do_reset();
    bus.Inst_Req_Valid = 1; bus.Inst_Addr = 32'h100;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.Bus_Req_Valid, bus.Bus_Addr, bus.Bus_Wen, bus.Bus_Wstrb} !== {1'b1, 32'h100, 1'b0, 4'h0}) begin
      failures++;
      $display("FAIL fetch_req: vld %b addr %h wen %b strb %h expected 1 00000100 0 0",
               bus.Bus_Req_Valid, bus.Bus_Addr, bus.Bus_Wen, bus.Bus_Wstrb);
    end
    serve(0, 0, 0, 32'h0000_0013);
    checks++;
    if ({snap_iack, snap_dack, snap_ivld, snap_instr, snap_rack} !== {3'b101, 32'h13, 1'b1}) begin
      failures++;
      $display("FAIL fetch_resp: iack %b dack %b ivld %b instr %h rack %b expected 1 0 1 00000013 1",
               snap_iack, snap_dack, snap_ivld, snap_instr, snap_rack);
    end
    #1;
    checks++;
    if ({bus.Bus_Req_Valid, bus.Inst_Valid, bus.Grant_Inst_Cnt} !== {2'b00, 32'd1}) begin
      failures++;
      $display("FAIL fetch_idle: bvld %b ivld %b gicnt %0d expected 0 0 1",
               bus.Bus_Req_Valid, bus.Inst_Valid, bus.Grant_Inst_Cnt);
    end
  endtask

  task automatic test_conflict;
    do_reset();
    bus.Inst_Req_Valid = 1; bus.Inst_Addr = 32'h400;
    bus.MemRead = 1; bus.Address = 32'h40;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      serve(0, 1, 0, $urandom);
      checks++;
      if ({snap_iack, snap_dack} !== ((k == 1) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL conflict_grant%0d: iack/dack %b expected %b", k, {snap_iack, snap_dack},
                 (k == 1) ? 2'b01 : 2'b10);
      end
      if (k < 2) begin bus.Inst_Req_Valid = 1; bus.MemRead = 1; end
    end
    bus.MemRead = 0;
    #1;
    checks++;
    if ({bus.Conflict_Cnt, bus.Grant_Inst_Cnt, bus.Grant_Data_Cnt} !== {32'd3, 32'd2, 32'd1}) begin
      failures++;
      $display("FAIL conflict_cnt: conf %0d gi %0d gd %0d expected 3 2 1",
               bus.Conflict_Cnt, bus.Grant_Inst_Cnt, bus.Grant_Data_Cnt);
    end
  endtask

  task automatic test_store;
    do_reset();
    bus.MemWrite = 1; bus.Address = 32'h200; bus.Write_data = 32'hDEADBEEF; bus.Write_strb = 4'b0011;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.Bus_Req_Valid, bus.Bus_Wen, bus.Bus_Wstrb, bus.Bus_Addr, bus.Bus_Wdata, bus.Mem_Req_Ack}
        !== {2'b11, 4'b0011, 32'h200, 32'hDEADBEEF, 1'b0}) begin
      failures++;
      $display("FAIL store_req: vld %b wen %b strb %b addr %h wdata %h mack %b expected 1 1 0011 00000200 deadbeef 0",
               bus.Bus_Req_Valid, bus.Bus_Wen, bus.Bus_Wstrb, bus.Bus_Addr, bus.Bus_Wdata, bus.Mem_Req_Ack);
    end
    bus.Bus_Req_Ack = 1;
    #1;
    checks++;
    if (bus.Mem_Req_Ack !== 1'b1) begin
      failures++;
      $display("FAIL store_ack: got %b expected 1", bus.Mem_Req_Ack);
    end
    @(negedge clk);
    bus.Bus_Req_Ack = 0; bus.MemWrite = 0;
    #1;
    checks++;
    if ({bus.Bus_Req_Valid, bus.Read_data_Valid, bus.Grant_Data_Cnt} !== {2'b00, 32'd1}) begin
      failures++;
      $display("FAIL store_idle: bvld %b rvld %b gdcnt %0d expected 0 0 1",
               bus.Bus_Req_Valid, bus.Read_data_Valid, bus.Grant_Data_Cnt);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    bus.MemRead = 1; bus.Address = 32'h300;
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({bus.Bus_Req_Valid, bus.Mem_Req_Ack} !== 2'b10) begin
        failures++;
        $display("FAIL bp_req%0d: vld/mack %b expected 10", c, {bus.Bus_Req_Valid, bus.Mem_Req_Ack});
      end
      @(negedge clk);
    end
    bus.Bus_Req_Ack = 1;
    @(negedge clk);
    bus.Bus_Req_Ack = 0; bus.MemRead = 0;
    bus.Bus_Rdata = 32'hCAFEF00D; bus.Bus_Rdata_Valid = 1; bus.Read_data_Ack = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({bus.Bus_Rdata_Ack, bus.Read_data_Valid, bus.Read_data} !== {2'b01, 32'hCAFEF00D}) begin
        failures++;
        $display("FAIL bp_resp%0d: rack %b rvld %b rdata %h expected 0 1 cafef00d",
                 c, bus.Bus_Rdata_Ack, bus.Read_data_Valid, bus.Read_data);
      end
      @(negedge clk);
    end
    bus.Read_data_Ack = 1;
    #1;
    checks++;
    if (bus.Bus_Rdata_Ack !== 1'b1) begin
      failures++;
      $display("FAIL bp_rack: got %b expected 1", bus.Bus_Rdata_Ack);
    end
    @(negedge clk);
    bus.Bus_Rdata_Valid = 0; bus.Read_data_Ack = 0; bus.Bus_Rdata = 0;
    #1;
    checks++;
    if ({bus.Read_data_Valid, bus.Bus_Req_Valid} !== 2'b00) begin
      failures++;
      $display("FAIL bp_idle: rvld/bvld %b expected 00", {bus.Read_data_Valid, bus.Bus_Req_Valid});
    end
  endtask

  task automatic test_random;
    bit          ip, dp, drd, dwr, g_inst, exp_last, exp_wen;
    logic [31:0] iaddr, daddr, wdata, rd, exp_addr, exp_wdata;
    logic [3:0]  strb, exp_strb;
    int          op, e_gi, e_gd, e_cf;
    do_reset();
    ip = 0; dp = 0; exp_last = 1; e_gi = 0; e_gd = 0; e_cf = 0;
    iaddr = 0; daddr = 0; wdata = 0; strb = 0; drd = 0; dwr = 0;
    for (int it = 0; it < 40; it++) begin
      if (!ip && ($urandom_range(0, 1) == 1)) begin
        ip = 1; iaddr = $urandom & 32'hFFFF_FFFC;
        bus.Inst_Req_Valid = 1; bus.Inst_Addr = iaddr;
      end
      if (!dp && ($urandom_range(0, 2) != 0)) begin
        dp = 1; op = $urandom_range(0, 2);
        drd = (op != 1); dwr = (op != 0);
        daddr = $urandom & 32'hFFFF_FFFC; wdata = $urandom; strb = 4'($urandom_range(0, 15));
        bus.MemRead = drd; bus.MemWrite = dwr; bus.Address = daddr;
        bus.Write_data = wdata; bus.Write_strb = strb;
      end
      if (!ip && !dp) begin
        ip = 1; iaddr = $urandom & 32'hFFFF_FFFC;
        bus.Inst_Req_Valid = 1; bus.Inst_Addr = iaddr;
      end
      // Round-robin reference: contention goes to the channel not granted last time.
      g_inst = ip && (!dp || exp_last);
      if (ip && dp) e_cf++;
      if (g_inst) begin e_gi++; exp_last = 0; end
      else        begin e_gd++; exp_last = 1; end
      exp_addr  = g_inst ? iaddr : daddr;
      exp_wen   = !g_inst && dwr;
      exp_strb  = exp_wen ? strb : 4'h0;
      exp_wdata = g_inst ? 32'h0 : wdata;
      @(posedge clk); @(negedge clk);
      checks++;
      if ({bus.Bus_Req_Valid, bus.Bus_Addr, bus.Bus_Wen, bus.Bus_Wstrb, bus.Bus_Wdata}
          !== {1'b1, exp_addr, exp_wen, exp_strb, exp_wdata}) begin
        failures++;
        $display("FAIL rand_req%0d: vld %b addr %h wen %b strb %h wdata %h expected 1 %h %b %h %h",
                 it, bus.Bus_Req_Valid, bus.Bus_Addr, bus.Bus_Wen, bus.Bus_Wstrb, bus.Bus_Wdata,
                 exp_addr, exp_wen, exp_strb, exp_wdata);
      end
      rd = $urandom;
      serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rd);
      checks++;
      if ({snap_iack, snap_dack} !== {g_inst, !g_inst}) begin
        failures++;
        $display("FAIL rand_owner%0d: iack/dack %b expected %b", it, {snap_iack, snap_dack}, {g_inst, !g_inst});
      end
      if (!exp_wen) begin
        checks++;
        if ({snap_ivld, snap_rvld, snap_rack, (g_inst ? snap_instr : snap_rdata)}
            !== {g_inst, !g_inst, 1'b1, rd}) begin
          failures++;
          $display("FAIL rand_resp%0d: ivld %b rvld %b rack %b instr %h rdata %h expected %b %b 1 data %h",
                   it, snap_ivld, snap_rvld, snap_rack, snap_instr, snap_rdata, g_inst, !g_inst, rd);
        end
      end
      #1;
      checks++;
      if (bus.Bus_Req_Valid !== 1'b0) begin
        failures++;
        $display("FAIL rand_idle%0d: bvld %b expected 0", it, bus.Bus_Req_Valid);
      end
      if (g_inst) ip = 0; else dp = 0;
    end
    checks++;
    if ({bus.Grant_Inst_Cnt, bus.Grant_Data_Cnt, bus.Conflict_Cnt} !== {e_gi[31:0], e_gd[31:0], e_cf[31:0]}) begin
      failures++;
      $display("FAIL rand_cnt: gi %0d gd %0d conf %0d expected %0d %0d %0d",
               bus.Grant_Inst_Cnt, bus.Grant_Data_Cnt, bus.Conflict_Cnt, e_gi, e_gd, e_cf);
    end
    bus.Inst_Req_Valid = 0; bus.MemRead = 0; bus.MemWrite = 0;
  endtask

  task automatic test_reset_mid_read;
    do_reset();
    bus.Inst_Req_Valid = 1; bus.Inst_Addr = 32'h10;
    @(posedge clk); @(negedge clk);
    serve(0, 0, 0, 32'h1);
    bus.MemRead = 1; bus.Address = 32'h80;
    @(posedge clk); @(negedge clk);
    bus.Bus_Req_Ack = 1;
    @(negedge clk);
    bus.Bus_Req_Ack = 0; bus.MemRead = 0;
    bus.Bus_Rdata = 32'h0000_1234; bus.Bus_Rdata_Valid = 1; bus.Read_data_Ack = 1;
    #1;
    checks++;
    if ({bus.Read_data_Valid, bus.Bus_Rdata_Ack} !== 2'b11) begin
      failures++;
      $display("FAIL mid_pre: rvld/rack %b expected 11", {bus.Read_data_Valid, bus.Bus_Rdata_Ack});
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.Read_data_Valid, bus.Bus_Rdata_Ack, bus.Read_data} !== 34'h0) begin
      failures++;
      $display("FAIL mid_drop: rvld %b rack %b rdata %h expected 0 0 0",
               bus.Read_data_Valid, bus.Bus_Rdata_Ack, bus.Read_data);
    end
    checks++;
    if ({bus.Grant_Inst_Cnt, bus.Grant_Data_Cnt, bus.Conflict_Cnt} !== 96'h0) begin
      failures++;
      $display("FAIL mid_cnt: gi %0d gd %0d conf %0d expected 0 0 0",
               bus.Grant_Inst_Cnt, bus.Grant_Data_Cnt, bus.Conflict_Cnt);
    end
    clear_inputs();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    bus.Inst_Req_Valid = 1; bus.Inst_Addr = 32'h500;
    bus.MemRead = 1; bus.Address = 32'h600;
    @(posedge clk); @(negedge clk);
    serve(0, 0, 0, 32'h77);
    checks++;
    if ({snap_iack, snap_dack} !== 2'b10) begin
      failures++;
      $display("FAIL mid_regrant: iack/dack %b expected 10", {snap_iack, snap_dack});
    end
    bus.MemRead = 0;
  endtask

  task automatic test_wrap;
    do_reset();
    force dut.grant_data_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.grant_data_cnt;
    #1;
    checks++;
    if (bus.Grant_Data_Cnt !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wrap_pre: got %h expected ffffffff", bus.Grant_Data_Cnt);
    end
    bus.MemRead = 1; bus.Address = 32'h900;
    @(posedge clk); @(negedge clk);
    serve(0, 0, 0, 32'h9);
    #1;
    checks++;
    if (bus.Grant_Data_Cnt !== 32'h0) begin
      failures++;
      $display("FAIL wrap: got %h expected 00000000", bus.Grant_Data_Cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_lone_fetch();
    test_conflict();
    test_store();
    test_backpressure();
    test_random();
    test_reset_mid_read();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
